// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: FSM states and
// default geometry of the instruction register and timing counter.
package ctrl_pkg;

  localparam int DEF_IR_W    = 16;
  localparam int DEF_OP_W    = 3;
  localparam int DEF_SC_W    = 4;
  localparam int DEF_INT_LEN = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    INTR = 2'd2
  } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Binary to one-hot decoder with an enable; output is all zero when disabled.
module onehot_dec #(
  parameter int W = 3
) (
  input  logic [W-1:0]      a,
  input  logic              en,
  output logic [2**W-1:0]   y
);

  localparam logic [2**W-1:0] BIT0 = {{(2**W-1){1'b0}}, 1'b1};

  // Decode the selected line.
  always_comb begin
    y = '0;
    if (en) begin
      y = BIT0 << a;
    end else begin
      y = '0;
    end
  end

endmodule

// File: rtl/seq_counter.sv
// Sequence counter with synchronous clear, increment and hold.
// wrap flags an increment from the all-ones value.
module seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inr,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] q_r;

  // Counter register; clr dominates inr.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (inr) begin
      q_r <= q_r + ONE;
    end else begin
      q_r <= q_r;
    end
  end

  assign q    = q_r;
  assign wrap = inr & ~clr & (q_r == {W{1'b1}});

endmodule

// File: rtl/control_sequencer.sv
// Hardwired timing/control sequencer: T-state generation, opcode decode,
// start/halt, memory stall, interrupt cycle and counter overflow detection.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W    = DEF_IR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int SC_W    = DEF_SC_W,
  parameter int INT_LEN = DEF_INT_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                halt,
  input  logic                stall,
  input  logic                seq_end,
  input  logic                irq,
  input  logic                ien,
  input  logic [IR_W-1:0]     ir,
  output logic [2**OP_W-1:0]  D,
  output logic                I,
  output logic [2**SC_W-1:0]  T,
  output logic                R,
  output logic                busy,
  output logic                sc_ovf
);

  localparam logic [SC_W-1:0] INT_LAST = SC_W'(INT_LEN - 1);

  state_e          state_r;
  state_e          state_s;
  logic            halt_pend_r;
  logic            halt_pend_s;
  logic            r_r;
  logic            r_s;
  logic            sc_ovf_r;
  logic            sc_clr_s;
  logic            sc_inr_s;
  logic            sc_wrap_s;
  logic [SC_W-1:0] sc_s;

  seq_counter #(.W(SC_W)) u_sc (
    .clk   (clk),
    .reset (reset),
    .clr   (sc_clr_s),
    .inr   (sc_inr_s),
    .q     (sc_s),
    .wrap  (sc_wrap_s)
  );

  onehot_dec #(.W(OP_W)) u_d_dec (
    .a  (ir[IR_W-2 -: OP_W]),
    .en (1'b1),
    .y  (D)
  );

  onehot_dec #(.W(SC_W)) u_t_dec (
    .a  (sc_s),
    .en (busy),
    .y  (T)
  );

  assign I      = ir[IR_W-1];
  assign busy   = (state_r != IDLE);
  assign R      = r_r;
  assign sc_ovf = sc_ovf_r;

  // Next-state logic: stall beats boundary handling, boundary beats increment.
  always_comb begin
    state_s     = state_r;
    halt_pend_s = halt_pend_r;
    r_s         = r_r;
    sc_clr_s    = 1'b0;
    sc_inr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) begin
          state_s  = RUN;
          sc_clr_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        if (stall) begin
          halt_pend_s = halt_pend_r | halt;
        end else if (seq_end) begin
          sc_clr_s = 1'b1;
          if (halt | halt_pend_r) begin
            state_s     = IDLE;
            halt_pend_s = 1'b0;
          end else if (irq & ien) begin
            state_s = INTR;
            r_s     = 1'b1;
          end else begin
            state_s = RUN;
          end
        end else begin
          sc_inr_s    = 1'b1;
          halt_pend_s = halt_pend_r | halt;
        end
      end
      INTR: begin
        if (stall) begin
          halt_pend_s = halt_pend_r | halt;
        end else if (sc_s == INT_LAST) begin
          sc_clr_s = 1'b1;
          r_s      = 1'b0;
          if (halt | halt_pend_r) begin
            state_s     = IDLE;
            halt_pend_s = 1'b0;
          end else begin
            state_s = RUN;
          end
        end else begin
          sc_inr_s    = 1'b1;
          halt_pend_s = halt_pend_r | halt;
        end
      end
      default: begin
        state_s     = IDLE;
        halt_pend_s = 1'b0;
        r_s         = 1'b0;
        sc_clr_s    = 1'b1;
      end
    endcase
  end

  // Control registers; sc_ovf is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      halt_pend_r <= 1'b0;
      r_r         <= 1'b0;
      sc_ovf_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      halt_pend_r <= halt_pend_s;
      r_r         <= r_s;
      sc_ovf_r    <= sc_ovf_r | sc_wrap_s;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a
// randomized run, all checked against a T-state-count reference model.
module tb_control_sequencer;

  localparam int INT_LEN = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic        seq_end = 1'b0;
  logic        irq = 1'b0;
  logic        ien = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic [7:0]  D;
  logic        I;
  logic [15:0] T;
  logic        R;
  logic        busy;
  logic        sc_ovf;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=stopped, 1=executing, 2=interrupt cycle; t = T-state index.
  int m_mode = 0;
  int m_t = 0;
  bit m_r = 1'b0;
  bit m_hp = 1'b0;
  bit m_ovf = 1'b0;

  control_sequencer #(
    .IR_W(16), .OP_W(3), .SC_W(4), .INT_LEN(INT_LEN)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .stall(stall),
    .seq_end(seq_end), .irq(irq), .ien(ien), .ir(ir),
    .D(D), .I(I), .T(T), .R(R), .busy(busy), .sc_ovf(sc_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_t();
    logic [15:0] one;
    one = 16'h0001;
    return (m_mode != 0) ? (one << m_t) : 16'h0000;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {exp_t(), m_r, (m_mode != 0), m_ovf};
  endfunction

  // Apply the current inputs to the model, then advance one clock.
  task automatic step();
    if (reset) begin
      m_mode = 0; m_t = 0; m_r = 1'b0; m_hp = 1'b0; m_ovf = 1'b0;
    end else if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_t = 0; end
    end else if (stall) begin
      m_hp = m_hp | halt;
    end else if (m_mode == 1 && seq_end) begin
      m_t = 0;
      if (halt || m_hp) begin m_mode = 0; m_hp = 1'b0; end
      else if (irq && ien) begin m_mode = 2; m_r = 1'b1; end
    end else if (m_mode == 2 && m_t == INT_LEN - 1) begin
      m_t = 0; m_r = 1'b0;
      if (halt || m_hp) begin m_mode = 0; m_hp = 1'b0; end
      else m_mode = 1;
    end else begin
      m_hp = m_hp | halt;
      if (m_t == 15) begin m_t = 0; m_ovf = 1'b1; end
      else m_t = m_t + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; run = 1'b0; halt = 1'b0; stall = 1'b0;
    seq_end = 1'b0; irq = 1'b0; ien = 1'b0;
  endtask

  task automatic do_reset_run();
    clear_inputs();
    reset = 1'b1; step(); reset = 1'b0;
    run = 1'b1; step(); run = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ir = 16'h3000;
    reset = 1'b1; step(); step(); reset = 1'b0;
    total++;
    if ({T, R, busy, sc_ovf} !== 19'h0) begin
      bad++; $display("FAIL reset: got T=%h R=%b busy=%b ovf=%b, want all 0", T, R, busy, sc_ovf);
    end
    run = 1'b0; seq_end = 1'b1; halt = 1'b1; irq = 1'b1; ien = 1'b1; stall = 1'b1;
    step(); clear_inputs();
    total++;
    if ({T, R, busy} !== {exp_t(), m_r, 1'b0}) begin
      bad++; $display("FAIL idle_ignore: got T=%h R=%b busy=%b, want T=0 idle", T, R, busy);
    end
  endtask

  task automatic test_walk();
    logic [15:0] want [5];
    want = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};
    ir = 16'h3000;
    do_reset_run();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (T !== want[k] || busy !== 1'b1 || T !== exp_t()) begin
        bad++; $display("FAIL walk[%0d]: got T=%h busy=%b, want T=%h busy=1", k, T, busy, want[k]);
      end
      seq_end = (k == 3);
      step();
    end
    seq_end = 1'b0;
    total++;
    if (D !== 8'h08 || I !== 1'b0) begin
      bad++; $display("FAIL decode: got D=%h I=%b, want D=08 I=0", D, I);
    end
  endtask

  task automatic test_stall();
    do_reset_run();
    step(); step();
    stall = 1'b1; seq_end = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (T !== 16'h0004 || T !== exp_t()) begin
        bad++; $display("FAIL stall[%0d]: got T=%h, want T=0004", k, T);
      end
    end
    stall = 1'b0;
    step();
    seq_end = 1'b0;
    total++;
    if (T !== 16'h0001) begin
      bad++; $display("FAIL stall_release: got T=%h, want T=0001", T);
    end
    step();
    total++;
    if (T !== 16'h0002 || busy !== 1'b1) begin
      bad++; $display("FAIL stall_single_boundary: got T=%h busy=%b, want T=0002 busy=1", T, busy);
    end
  endtask

  task automatic test_intr();
    logic [15:0] want_t [4];
    logic        want_r [4];
    want_t = '{16'h0001, 16'h0002, 16'h0004, 16'h0001};
    want_r = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset_run();
    irq = 1'b1; ien = 1'b1; seq_end = 1'b1;
    step();
    seq_end = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (T !== want_t[k] || R !== want_r[k] || {T, R} !== {exp_t(), m_r}) begin
        bad++; $display("FAIL intr[%0d]: got T=%h R=%b, want T=%h R=%b", k, T, R, want_t[k], want_r[k]);
      end
      step();
    end
    ien = 1'b0; seq_end = 1'b1;
    step();
    seq_end = 1'b0;
    total++;
    if (R !== 1'b0 || T !== 16'h0001) begin
      bad++; $display("FAIL intr_disabled: got T=%h R=%b, want T=0001 R=0", T, R);
    end
    irq = 1'b0;
  endtask

  task automatic test_halt();
    do_reset_run();
    step();
    halt = 1'b1; step(); halt = 1'b0;
    step(); step();
    total++;
    if (T !== 16'h0010) begin
      bad++; $display("FAIL halt_t4: got T=%h, want T=0010", T);
    end
    seq_end = 1'b1; irq = 1'b1; ien = 1'b1;
    step();
    clear_inputs();
    total++;
    if ({T, R, busy} !== {16'h0000, 1'b0, 1'b0} || busy !== (m_mode != 0)) begin
      bad++; $display("FAIL halt_pending: got T=%h R=%b busy=%b, want T=0 R=0 busy=0", T, R, busy);
    end
    run = 1'b1; step(); run = 1'b0;
    step();
    halt = 1'b1; seq_end = 1'b1; irq = 1'b1; ien = 1'b1;
    step();
    clear_inputs();
    total++;
    if ({T, R, busy} !== {16'h0000, 1'b0, 1'b0}) begin
      bad++; $display("FAIL halt_same_cycle: got T=%h R=%b busy=%b, want T=0 R=0 busy=0", T, R, busy);
    end
  endtask

  task automatic test_wrap();
    do_reset_run();
    for (int k = 0; k < 15; k++) step();
    total++;
    if (T !== 16'h8000 || sc_ovf !== 1'b0) begin
      bad++; $display("FAIL wrap_top: got T=%h ovf=%b, want T=8000 ovf=0", T, sc_ovf);
    end
    step();
    total++;
    if (T !== 16'h0001 || sc_ovf !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL wrap: got T=%h ovf=%b busy=%b, want T=0001 ovf=1 busy=1", T, sc_ovf, busy);
    end
    seq_end = 1'b1; halt = 1'b1; step(); clear_inputs();
    step(); step();
    total++;
    if (sc_ovf !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ovf_sticky: got ovf=%b busy=%b, want ovf=1 busy=0", sc_ovf, busy);
    end
  endtask

  task automatic test_reset_intr();
    do_reset_run();
    irq = 1'b1; ien = 1'b1; seq_end = 1'b1; step();
    seq_end = 1'b0; step();
    total++;
    if (T !== 16'h0002 || R !== 1'b1) begin
      bad++; $display("FAIL intr_t1: got T=%h R=%b, want T=0002 R=1", T, R);
    end
    reset = 1'b1; step(); reset = 1'b0;
    total++;
    if ({T, R, busy, sc_ovf} !== 19'h0) begin
      bad++; $display("FAIL reset_in_intr: got T=%h R=%b busy=%b ovf=%b, want all 0", T, R, busy, sc_ovf);
    end
    clear_inputs();
    run = 1'b1; step(); run = 1'b0;
    total++;
    if (T !== 16'h0001 || R !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL restart: got T=%h R=%b busy=%b, want T=0001 R=0 busy=1", T, R, busy);
    end
  endtask

  task automatic test_random();
    logic [7:0] d_exp;
    clear_inputs();
    reset = 1'b1; step(); reset = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 99) == 0);
      run     = ($urandom_range(0, 3) == 0);
      halt    = ($urandom_range(0, 15) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      seq_end = ($urandom_range(0, 4) == 0);
      irq     = $urandom_range(0, 1);
      ien     = $urandom_range(0, 1);
      ir      = 16'($urandom());
      #1;
      d_exp = 8'h01 << ir[14:12];
      total++;
      if (D !== d_exp || I !== ir[15]) begin
        bad++; $display("FAIL rand_decode[%0d]: got D=%h I=%b, want D=%h I=%b", k, D, I, d_exp, ir[15]);
      end
      step();
      total++;
      if ({T, R, busy, sc_ovf} !== exp_vec()) begin
        bad++; $display("FAIL rand[%0d]: got T=%h R=%b busy=%b ovf=%b, want T=%h R=%b busy=%b ovf=%b",
                        k, T, R, busy, sc_ovf, exp_t(), m_r, (m_mode != 0), m_ovf);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_walk();
    test_stall();
    test_intr();
    test_halt();
    test_wrap();
    test_reset_intr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
